// File: rtl/bd_axi256_pkg.sv
// Shared constants and types for the 256-bit single-beat AXI4 write path.
package bd_axi256_pkg;
   localparam int ADDR_W     = 64;
   localparam int DATA_W     = 256;
   localparam int STRB_W     = DATA_W / 8;
   localparam int MEM_DEPTH  = 16;
   localparam int IDX_W      = $clog2(MEM_DEPTH);
   localparam int BYTE_SHIFT = $clog2(STRB_W);

   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_WAIT_B = 2'd2,
      ST_DONE   = 2'd3
   } writer_state_t;
endpackage

// File: rtl/bd_axi256_wrapper_slave.sv
// AXI4 write-only memory slave: independent AW/W capture slots, commit, single B response.
module axi4_mem_slave
   import bd_axi256_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_awaddr,
   input  logic [7:0]        i_awlen,
   input  logic [2:0]        i_awsize,
   input  logic [1:0]        i_awburst,
   input  logic              i_awvalid,
   output logic              o_awready,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [STRB_W-1:0] i_wstrb,
   input  logic              i_wlast,
   input  logic              i_wvalid,
   output logic              o_wready,
   output logic [1:0]        o_bresp,
   output logic              o_bvalid,
   input  logic              i_bready
);
   logic              r_aw_full;
   logic              r_w_full;
   logic              r_bvalid;
   logic [IDX_W-1:0]  r_aw_idx;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_commit;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              w_unused_bits;

   assign o_awready = !r_aw_full && !r_bvalid;
   assign o_wready  = !r_w_full && !r_bvalid;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = AXI_RESP_OKAY;

   assign w_aw_hs  = i_awvalid && o_awready;
   assign w_w_hs   = i_wvalid && o_wready;
   // Commit as soon as both halves are present, whether captured earlier or arriving now.
   assign w_commit = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
   assign w_idx    = r_aw_full ? r_aw_idx : i_awaddr[BYTE_SHIFT +: IDX_W];
   assign w_data   = r_w_full ? r_wdata : i_wdata;
   assign w_strb   = r_w_full ? r_wstrb : i_wstrb;

   assign w_unused_bits = ^{i_awaddr[ADDR_W-1:BYTE_SHIFT+IDX_W], i_awaddr[BYTE_SHIFT-1:0],
                            i_awlen, i_awsize, i_awburst, i_wlast};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else if (w_commit) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_bvalid  <= 1'b1;
      end else begin
         if (w_aw_hs) r_aw_full <= 1'b1;
         if (w_w_hs)  r_w_full  <= 1'b1;
         if (r_bvalid && i_bready) r_bvalid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_aw_hs) r_aw_idx <= i_awaddr[BYTE_SHIFT +: IDX_W];
      if (w_w_hs) begin
         r_wdata <= i_wdata;
         r_wstrb <= i_wstrb;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_commit && !i_rst) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end
endmodule

// File: rtl/bd_axi256_wrapper.sv
// Start/ready/idle/done controlled single-beat AXI4 writer in front of an internal memory slave.
//   state     | meaning
//   ST_IDLE   | waiting for start; ready mirrors start
//   ST_WRITE  | AW and W valid until each handshakes
//   ST_WAIT_B | BREADY high, waiting for write response
//   ST_DONE   | one-cycle done pulse
module bd_axi256_wrapper
   import bd_axi256_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              writer_start,
   input  logic [ADDR_W-1:0] writer_addr,
   input  logic [DATA_W-1:0] writer_data,
   output logic              writer_ready,
   output logic              writer_idle,
   output logic              writer_done
);
   writer_state_t     r_state;
   writer_state_t     w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_aw_done;
   logic              r_w_done;

   logic              w_awvalid;
   logic              w_awready;
   logic              w_wvalid;
   logic              w_wready;
   logic              w_bvalid;
   logic              w_bready;
   logic [1:0]        w_bresp;
   logic [ADDR_W-1:0] w_awaddr;
   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_accept;
   logic              w_unused_bresp;

   assign w_awaddr       = r_addr << BYTE_SHIFT;
   assign w_accept       = (r_state == ST_IDLE) && writer_start;
   assign w_aw_hs        = (r_state == ST_WRITE) && !r_aw_done && w_awready;
   assign w_w_hs         = (r_state == ST_WRITE) && !r_w_done && w_wready;
   assign w_unused_bresp = ^w_bresp;

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      writer_ready = 1'b0;
      writer_idle  = 1'b0;
      writer_done  = 1'b0;
      w_awvalid    = 1'b0;
      w_wvalid     = 1'b0;
      w_bready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            writer_idle  = 1'b1;
            writer_ready = writer_start;
            if (writer_start) w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            w_awvalid = !r_aw_done;
            w_wvalid  = !r_w_done;
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = ST_WAIT_B;
         end
         ST_WAIT_B: begin
            w_bready = 1'b1;
            if (w_bvalid) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            writer_done = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || r_state != ST_WRITE) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_accept && !reset) begin
         r_addr <= writer_addr;
         r_data <= writer_data;
      end
   end

   axi4_mem_slave u_slave (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_awaddr  (w_awaddr),
      .i_awlen   (AXI_LEN_SINGLE),
      .i_awsize  (AXI_SIZE_32B),
      .i_awburst (AXI_BURST_INCR),
      .i_awvalid (w_awvalid),
      .o_awready (w_awready),
      .i_wdata   (r_data),
      .i_wstrb   ({STRB_W{1'b1}}),
      .i_wlast   (1'b1),
      .i_wvalid  (w_wvalid),
      .o_wready  (w_wready),
      .o_bresp   (w_bresp),
      .o_bvalid  (w_bvalid),
      .i_bready  (w_bready)
   );
endmodule

// File: tb/tb_bd_axi256_wrapper.sv
// Bench for bd_axi256_wrapper: transaction-level memory model, randomized and directed writes.
module tb_bd_axi256_wrapper;
   import bd_axi256_pkg::*;

   logic              clock;
   logic              reset;
   logic              writer_start;
   logic [ADDR_W-1:0] writer_addr;
   logic [DATA_W-1:0] writer_data;
   logic              writer_ready;
   logic              writer_idle;
   logic              writer_done;

   logic [DATA_W-1:0] exp_mem [MEM_DEPTH];
   int n_cmp = 0;
   int n_err = 0;

   bd_axi256_wrapper dut (
      .clock        (clock),
      .reset        (reset),
      .writer_start (writer_start),
      .writer_addr  (writer_addr),
      .writer_data  (writer_data),
      .writer_ready (writer_ready),
      .writer_idle  (writer_idle),
      .writer_done  (writer_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic int idx_of(input logic [ADDR_W-1:0] a);
      return int'(a % MEM_DEPTH);
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      writer_start = 1'b0;
      @(negedge clock);
      while (!writer_idle && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) chk("idle_timeout", writer_idle, 1);
   endtask

   // One complete transaction; optionally keeps start high with other data while busy.
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input bit poke);
      wait_idle();
      writer_start = 1'b1;
      writer_addr  = a;
      writer_data  = d;
      #1;
      chk("ready_accept", writer_ready, 1);
      @(negedge clock);
      writer_start = poke;
      writer_addr  = a + 3;
      writer_data  = ~d;
      #1;
      chk("busy1_ready", writer_ready, 0);
      chk("busy1_idle", writer_idle, 0);
      chk("busy1_done", writer_done, 0);
      @(negedge clock);
      #1;
      chk("busy2_ready", writer_ready, 0);
      chk("busy2_done", writer_done, 0);
      @(negedge clock);
      #1;
      chk("done_pulse", writer_done, 1);
      chk("done_ready", writer_ready, 0);
      writer_start = 1'b0;
      @(negedge clock);
      #1;
      chk("after_done", writer_done, 0);
      chk("after_idle", writer_idle, 1);
      exp_mem[idx_of(a)] = d;
   endtask

   task automatic sweep_mem(input string tag);
      for (int i = 0; i < MEM_DEPTH; i++)
         chk($sformatf("%s_mem%0d", tag, i), dut.u_slave.r_mem[i], exp_mem[i]);
   endtask

   initial begin
      int dones;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;

      reset        = 1'b1;
      writer_start = 1'b0;
      writer_addr  = '0;
      writer_data  = '0;

      @(posedge clock);
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         chk("rst_idle", writer_idle, 1);
         chk("rst_ready", writer_ready, 0);
         chk("rst_done", writer_done, 0);
         chk("rst_axi_valids", {dut.w_awvalid, dut.w_wvalid, dut.w_bvalid, dut.w_bready}, 0);
      end
      reset = 1'b0;

      // Fill every word so later "untouched" checks compare against known contents.
      for (int i = 0; i < MEM_DEPTH; i++) begin
         a = {$urandom, $urandom};
         a[IDX_W-1:0] = IDX_W'(i);
         do_write(a, rand256(), 1'b0);
      end
      sweep_mem("fill");

      do_write(64'd1, 256'd101, 1'b0);
      chk("basic_mem1", dut.u_slave.r_mem[1], 256'd101);

      // Start held high with changing inputs: accepts only every fourth cycle.
      wait_idle();
      dones = 0;
      for (int i = 0; i < 7; i++) begin
         writer_start = 1'b1;
         writer_addr  = ADDR_W'(i + 1);
         writer_data  = DATA_W'(101 + i);
         #1;
         chk($sformatf("b2b_ready%0d", i), writer_ready, (i % 4 == 0) ? 1 : 0);
         if (writer_done) dones++;
         @(negedge clock);
      end
      writer_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (writer_done) dones++;
         @(negedge clock);
      end
      chk("b2b_done_count", dones, 2);
      exp_mem[1] = 256'd101;
      exp_mem[5] = 256'd105;
      sweep_mem("b2b");

      do_write(64'd17, 256'hAA, 1'b1);
      chk("wrap_mem1", dut.u_slave.r_mem[1], 256'hAA);

      // Reset while waiting for the B response: the write is already in memory.
      a = 64'd6;
      d = rand256();
      wait_idle();
      writer_start = 1'b1;
      writer_addr  = a;
      writer_data  = d;
      @(negedge clock);
      writer_start = 1'b0;
      @(negedge clock);
      #1;
      chk("abort_in_wait_b", dut.w_bready, 1);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("abort_idle", writer_idle, 1);
      chk("abort_done", writer_done, 0);
      chk("abort_valids", {dut.w_awvalid, dut.w_wvalid, dut.w_bvalid}, 0);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (writer_done) dones++;
      end
      chk("abort_no_done", dones, 0);
      exp_mem[idx_of(a)] = d;
      do_write(64'd9, rand256(), 1'b0);
      sweep_mem("abort");

      for (int t = 0; t < 24; t++) begin
         a = {$urandom, $urandom};
         do_write(a, rand256(), 1'($urandom_range(0, 1)));
      end
      sweep_mem("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
